// File: rtl/serial_frame_rx.sv
// ============================================================================
//  Module      : serial_frame_rx
//  Description : MSB-first serial frame receiver. It detects a start bit,
//                collects DATA_W data bits and an optional even-parity bit,
//                and presents each word through a one-entry valid/ready
//                holding register with a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_s,
  input  logic              i_ready,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_perr,
  output logic              o_overflow,
  output logic              o_busy
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [DATA_W-1:0] w_word;
  logic              w_done;
  logic              w_err;

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ovf;
  logic              w_pop;
  logic              w_load;
  logic              w_drop;

  // --------------------------------------------------------------------------
  // Frame state machine: state, bit counter and shift accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_word      = r_acc;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_s) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        w_acc_nxt = {r_acc[DATA_W-2:0], i_s};
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == C_LAST_CNT) begin
          if (PARITY_EN != 0) begin
            w_state_nxt = S_PARITY;
          end else begin
            // Without parity the last data bit completes the frame; the word
            // must include the bit sampled on this edge.
            w_done      = 1'b1;
            w_word      = w_acc_nxt;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_PARITY: begin
        w_done      = 1'b1;
        w_err       = ^{r_acc, i_s};
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One-entry holding register with overflow detection
  // --------------------------------------------------------------------------
  assign w_pop  = r_valid & i_ready;
  assign w_load = w_done & (~r_valid | w_pop);
  assign w_drop = w_done & r_valid & ~i_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_word;
      r_perr  <= w_err;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (i_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_perr     = r_perr;
  assign o_overflow = r_ovf;
  assign o_busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
// ============================================================================
//  Module      : tb_serial_frame_rx
//  Description : Directed and randomized bench for serial_frame_rx against a
//                frame-level reference model of the holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_frame_rx;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_s;
  logic       i_ready;
  logic       i_clr;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_perr;
  logic       o_overflow;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the consumer should see after each edge.
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_perr;
  logic       m_ovf;
  logic       cur_rdy;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_s        (i_s),
    .i_ready    (i_ready),
    .i_clr      (i_clr),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_perr     (o_perr),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic busy_exp);
    chk("valid", {31'd0, o_valid}, {31'd0, m_valid});
    chk("busy", {31'd0, o_busy}, {31'd0, busy_exp});
    chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
    if (m_valid) begin
      chk("data", {24'd0, o_data}, {24'd0, m_data});
      chk("perr", {31'd0, o_perr}, {31'd0, m_perr});
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  // done/w/e describe a frame that ends on this edge (known from stimulus).
  task automatic cyc(input logic s, input logic rdy, input logic clr,
                     input logic busy_exp, input logic done,
                     input logic [7:0] w, input logic e);
    logic pop;
    i_s     = s;
    i_ready = rdy;
    i_clr   = clr;
    @(posedge i_clk);
    pop = m_valid & rdy;
    if (done && m_valid && !pop) m_ovf = 1'b1;
    else if (clr)                m_ovf = 1'b0;
    if (done && (!m_valid || pop)) begin
      m_data  = w;
      m_perr  = e;
      m_valid = 1'b1;
    end else if (!done && pop) begin
      m_valid = 1'b0;
    end
    #1;
    check_all(busy_exp);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, rdy, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // rmode 0: hold cur_rdy; 1: random ready/clr per bit; 2: cur_rdy but
  // last_rdy on the parity edge. flip inverts the correct parity bit.
  task automatic send_frame(input logic [7:0] w, input logic flip,
                            input int rmode, input logic last_rdy);
    logic [9:0] bits;
    logic       rdy;
    logic       clr;
    bits = {1'b1, w, (^w) ^ flip};
    for (int k = 9; k >= 0; k--) begin
      rdy = cur_rdy;
      clr = 1'b0;
      if (rmode == 1) begin
        rdy = 1'($urandom_range(0, 1));
        clr = ($urandom_range(0, 15) == 0);
      end else if (rmode == 2 && k == 0) begin
        rdy = last_rdy;
      end
      cyc(bits[k], rdy, clr, (k != 0), (k == 0), w, flip);
    end
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_perr  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, {24'd0, o_data}, 32'd0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_perr"}, {31'd0, o_perr}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, o_overflow}, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    logic       flip;
    int         gap;

    // Reset and a quiet line
    i_rstn  = 1'b0;
    i_s     = 1'b0;
    i_ready = 1'b0;
    i_clr   = 1'b0;
    cur_rdy = 1'b0;
    model_reset();
    #12;
    check_zero("rst");
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("idle_data", {24'd0, o_data}, 32'd0);
    end

    // Clean frame 0xA5
    cur_rdy = 1'b1;
    send_frame(8'hA5, 1'b0, 0, 1'b1);
    chk("a5_data", {24'd0, o_data}, 32'hA5);
    chk("a5_perr", {31'd0, o_perr}, 32'd0);

    // Frame 0x3C with a wrong parity bit
    send_frame(8'h3C, 1'b1, 0, 1'b1);
    chk("3c_data", {24'd0, o_data}, 32'h3C);
    chk("3c_perr", {31'd0, o_perr}, 32'd1);
    idle(1, 1'b1);

    // Back-to-back with a stalled consumer: the second frame is dropped
    cur_rdy = 1'b0;
    send_frame(8'h11, 1'b0, 0, 1'b0);
    send_frame(8'h22, 1'b0, 0, 1'b0);
    chk("ovf_data", {24'd0, o_data}, 32'h11);
    chk("ovf_flag", {31'd0, o_overflow}, 32'd1);
    idle(1, 1'b1);
    chk("pop_valid", {31'd0, o_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("clr_ovf", {31'd0, o_overflow}, 32'd0);

    // Pop and load on the same edge
    send_frame(8'h55, 1'b0, 0, 1'b0);
    send_frame(8'h81, 1'b0, 2, 1'b1);
    chk("swap_valid", {31'd0, o_valid}, 32'd1);
    chk("swap_data", {24'd0, o_data}, 32'h81);
    chk("swap_ovf", {31'd0, o_overflow}, 32'd0);
    idle(1, 1'b1);

    // Asynchronous reset part-way through 0xF0
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    #2;
    i_rstn = 1'b0;
    #1;
    model_reset();
    check_zero("arst");
    @(posedge i_clk);
    #1;
    check_zero("arst_hold");
    @(negedge i_clk);
    i_rstn  = 1'b1;
    cur_rdy = 1'b1;
    send_frame(8'h81, 1'b0, 0, 1'b1);
    chk("post_rst_data", {24'd0, o_data}, 32'h81);
    chk("post_rst_perr", {31'd0, o_perr}, 32'd0);

    // Randomized frames, gaps, back-pressure and clears
    for (int f = 0; f < 300; f++) begin
      w    = 8'($urandom);
      flip = ($urandom_range(0, 7) == 0);
      send_frame(w, flip, 1, 1'b0);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        cyc(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            1'b0, 1'b0, 8'h00, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Frame receiver that sits directly downstream of the 8-bit shift register's serial output (o_s).
- Samples the MSB-first serial stream once per clock, detects a start bit and collects DATA_W data bits plus an optional even-parity bit.
- Presents each received word on a valid/ready output through a one-entry holding register to the consuming logic.
- Reports parity errors per word and a sticky overflow flag when a completed frame cannot be stored.

Parameters:
- DATA_W, 8, number of data bits per frame (MSB first); legal range 2..32.
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit, and o_perr is tied to 0.

Ports:
- i_clk, input, 1, single clock; every edge samples one serial bit.
- i_rstn, input, 1, asynchronous active-low reset.
- i_s, input, 1, serial data line; idles at 0.
- i_ready, input, 1, consumer accepts o_data on an edge where o_valid=1 and i_ready=1.
- i_clr, input, 1, synchronous clear of o_overflow.
- o_data, output, DATA_W, received word held in the holding register.
- o_valid, output, 1, holding register occupied.
- o_perr, output, 1, parity error for the word currently in o_data; meaningful only while o_valid=1.
- o_overflow, output, 1, sticky flag: a completed frame was dropped.
- o_busy, output, 1, receiver is mid-frame (state is not IDLE).

Behaviour:
- Reset (asynchronous, i_rstn=0): state=IDLE, bit counter=0, shift accumulator=0, o_data=0, o_valid=0, o_perr=0, o_overflow=0, o_busy=0. Reset mid-frame discards the partial frame.
- Frame format:
  - Start bit = 1.
  - Then DATA_W data bits, MSB first.
  - Then, if PARITY_EN=1, one parity bit chosen so the count of 1s over data+parity is even.
  - No stop bit.
- State machine (one i_s sample per edge):
  - IDLE: if i_s=1, go to DATA and clear the bit counter; otherwise stay. Zeros on an idle line never produce output.
  - DATA: shift i_s into the accumulator LSB side (acc <= {acc[DATA_W-2:0], i_s}) and increment the counter. On the edge sampling the DATA_W-th bit, go to PARITY if PARITY_EN=1; otherwise complete the frame and go to IDLE.
  - PARITY: sample the parity bit, compute err = ^{acc, i_s}, complete the frame, and go to IDLE.
- A new start bit is accepted on the edge immediately after the frame's final bit, so back-to-back frames are supported. The final bit itself is never treated as a start bit.
- o_busy = (state != IDLE), registered state decode.
- Completion, on the edge sampling the last frame bit (let pop = o_valid & i_ready):
  - If o_valid=0 or pop=1: load o_data with the complete word (including the bit sampled this edge) and o_perr with err (0 when PARITY_EN=0); set o_valid=1.
  - Else: drop the frame; o_data and o_perr are unchanged; set o_overflow=1.
- Timing: o_valid is visible the cycle after the final bit is sampled, a latency of 1 clock from the last bit.
- When there is no completion: pop=1 clears o_valid to 0; o_data and o_perr hold their values.
- o_data must not change while o_valid=1 and i_ready=0.
- o_overflow: set on a dropped frame and cleared by i_clr. If i_clr and a drop occur on the same edge, set wins.
- Bit counter width: $clog2(DATA_W)+1. No wrap-around; the counter is cleared on entry to DATA.

Test Plan:
1. Reset, i_s=0 for 20 clocks → o_valid=0, o_busy=0 throughout; all outputs 0.
2. i_ready=1; drive 1, then the bits of 0xA5 MSB first (1,0,1,0,0,1,0,1), then parity 0 → one clock later o_valid=1, o_data=0xA5, o_perr=0; o_busy high for exactly 9 clocks.
3. Frame 0x3C with parity bit 1 → o_data=0x3C, o_perr=1, o_overflow=0.
4. i_ready=0; send 0x11 then 0x22 back-to-back → o_data stays 0x11, o_overflow=1; raise i_ready for 1 clock → o_valid=0; pulse i_clr → o_overflow=0.
5. Word 0x55 held with i_ready=0; raise i_ready on the same edge that the parity bit of 0x81 is sampled → o_valid stays 1, o_data=0x81, o_overflow=0.
6. Assert i_rstn=0 after the 4th data bit of 0xF0 → all outputs 0 immediately; after release, frame 0x81 is received as 0x81 with o_perr=0.
